commit_trace_sched: RTL and testbench

// - Merges the two commit lanes of the core into one in-order stream of retire records (inst, dnpc, kill, invalid).
// - Buffers the records in a FIFO and drains one per accepted handshake to the DPI instruction-trace sink.
// - Back-pressures commit while space is short. Stops the stream cleanly after an invalid instruction retires.

---
 rtl/commit_trace_sched.sv | 180 ++++++++++++++++++
 tb/tb_commit_trace_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_sched.sv
// commit_trace_sched: merges the two in-order commit lanes into a single
// retire-record stream, buffers it in a small FIFO and hands it to the
// instruction-trace sink one record per accepted handshake. Once an invalid
// instruction retires, commit is shut off, the FIFO drains and the block
// parks in a terminal halted state until reset.
module commit_trace_sched #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            c0_valid,
    input  logic [31:0]     c0_inst,
    input  logic [XLEN-1:0] c0_dnpc,
    input  logic            c0_kill,
    input  logic            c0_invalid,

    input  logic            c1_valid,
    input  logic [31:0]     c1_inst,
    input  logic [XLEN-1:0] c1_dnpc,
    input  logic            c1_kill,
    input  logic            c1_invalid,

    output logic            commit_stall,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_dnpc,
    output logic            out_kill,
    output logic            out_invalid,

    output logic            halted,
    output logic            overflow_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] dnpc;
        logic            kill;
        logic            invalid;
    } rec_t;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;

    rec_t            mem [DEPTH];

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [CW-1:0]   free;
    logic            stall;
    logic            any_valid;
    logic            enq0;
    logic            enq1;
    logic [CW-1:0]   enq_cnt;
    logic [PW-1:0]   lane1_slot;
    logic            pop;
    logic            enq_invalid;
    rec_t            rec0;
    rec_t            rec1;
    rec_t            head;

    // Stall, enqueue and pop decisions, all from registered state only.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        // Two free slots are reserved so a dual-lane retire never needs a partial accept.
        stall     = (state_q != StRun) || (free < CW'(2));
        any_valid = c0_valid | c1_valid;

        enq0 = !stall && c0_valid;
        // The younger lane is discarded behind an illegal older instruction.
        enq1 = !stall && c1_valid && !(c0_valid && c0_invalid);

        enq_cnt     = CW'(enq0) + CW'(enq1);
        lane1_slot  = wr_ptr_q + PW'(enq0);
        enq_invalid = (enq0 && c0_invalid) || (enq1 && c1_invalid);

        pop = out_valid && out_ready;

        count_d    = count_q + enq_cnt - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(enq_cnt);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = overflow_q || (any_valid && stall);
    end

    // Lane records as stored in the FIFO.
    always_comb begin
        rec0 = '{inst: c0_inst, dnpc: c0_dnpc, kill: c0_kill, invalid: c0_invalid};
        rec1 = '{inst: c1_inst, dnpc: c1_dnpc, kill: c1_kill, invalid: c1_invalid};
    end

    // Sequencing FSM: RUN until an invalid record is accepted, DRAIN until empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (enq_invalid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Includes the edge that pops the last buffered record.
                if (count_d == '0) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (enq0) begin
            mem[wr_ptr_q] <= rec0;
        end
        if (enq1) begin
            mem[lane1_slot] <= rec1;
        end
    end

    // Output view of the head entry, zeroed whenever the FIFO is empty.
    always_comb begin
        head         = mem[rd_ptr_q];
        out_valid    = (count_q != '0) && (state_q != StHalted);
        out_inst     = '0;
        out_dnpc     = '0;
        out_kill     = 1'b0;
        out_invalid  = 1'b0;
        if (out_valid) begin
            out_inst    = head.inst;
            out_dnpc    = head.dnpc;
            out_kill    = head.kill;
            out_invalid = head.invalid;
        end
        commit_stall = stall;
        halted       = (state_q == StHalted);
        overflow_err = overflow_q;
    end

endmodule

// File: tb/tb_commit_trace_sched.sv
// Randomised plus directed bench for commit_trace_sched against a queue-based
// model of the retire stream.
module tb_commit_trace_sched;

    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            c0_valid, c0_kill, c0_invalid;
    logic [31:0]     c0_inst;
    logic [XLEN-1:0] c0_dnpc;
    logic            c1_valid, c1_kill, c1_invalid;
    logic [31:0]     c1_inst;
    logic [XLEN-1:0] c1_dnpc;
    logic            commit_stall;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_dnpc;
    logic            out_kill, out_invalid;
    logic            halted, overflow_err;

    commit_trace_sched #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .c0_valid     (c0_valid),
        .c0_inst      (c0_inst),
        .c0_dnpc      (c0_dnpc),
        .c0_kill      (c0_kill),
        .c0_invalid   (c0_invalid),
        .c1_valid     (c1_valid),
        .c1_inst      (c1_inst),
        .c1_dnpc      (c1_dnpc),
        .c1_kill      (c1_kill),
        .c1_invalid   (c1_invalid),
        .commit_stall (commit_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_dnpc     (out_dnpc),
        .out_kill     (out_kill),
        .out_invalid  (out_invalid),
        .halted       (halted),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     inst;
        logic [XLEN-1:0] dnpc;
        logic            kill;
        logic            invalid;
    } rec_t;

    // Reference model: the buffered retire stream plus three status flags.
    rec_t q[$];
    bit   m_drain, m_halt, m_ovf;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        return m_halt || m_drain || ((DEPTH - q.size()) < 2);
    endfunction

    task automatic check_outputs();
        check("commit_stall", 64'(commit_stall), 64'(model_stall()));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_inst", 64'(out_inst), 64'(q[0].inst));
            check("out_dnpc", out_dnpc, q[0].dnpc);
            check("out_kill", 64'(out_kill), 64'(q[0].kill));
            check("out_invalid", 64'(out_invalid), 64'(q[0].invalid));
        end else begin
            check("out_inst_idle", 64'(out_inst), 64'h0);
            check("out_dnpc_idle", out_dnpc, 64'h0);
            check("out_flags_idle", 64'({out_kill, out_invalid}), 64'h0);
        end
        check("halted", 64'(halted), 64'(m_halt));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    endtask

    task automatic model_clear();
        q.delete();
        m_drain = 1'b0;
        m_halt  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic drive_idle();
        c0_valid = 0; c0_inst = '0; c0_dnpc = '0; c0_kill = 0; c0_invalid = 0;
        c1_valid = 0; c1_inst = '0; c1_dnpc = '0; c1_kill = 0; c1_invalid = 0;
        out_ready = 0;
    endtask

    // Called just after a negedge: check, drive, advance model, run one clock.
    task automatic step(input bit v0, input logic [31:0] i0, input logic [63:0] d0,
                        input bit k0, input bit x0,
                        input bit v1, input logic [31:0] i1, input logic [63:0] d1,
                        input bit k1, input bit x1, input bit rdy);
        bit st;
        check_outputs();
        c0_valid = v0; c0_inst = i0; c0_dnpc = d0; c0_kill = k0; c0_invalid = x0;
        c1_valid = v1; c1_inst = i1; c1_dnpc = d1; c1_kill = k1; c1_invalid = x1;
        out_ready = rdy;

        st = model_stall();
        if ((q.size() > 0) && rdy) void'(q.pop_front());
        if ((v0 || v1) && st) begin
            m_ovf = 1'b1;
        end else if (!st) begin
            if (v0) begin
                q.push_back('{i0, d0, k0, x0});
                if (x0) m_drain = 1'b1;
            end
            if (v1 && !(v0 && x0)) begin
                q.push_back('{i1, d1, k1, x1});
                if (x1) m_drain = 1'b1;
            end
        end
        if (m_drain && q.size() == 0) begin
            m_drain = 1'b0;
            m_halt  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic lane0(input logic [31:0] i, input bit k, input bit x, input bit rdy);
        step(1, i, 64'h8000_0000 + 64'(i), k, x, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic lanes(input logic [31:0] i0, input logic [31:0] i1, input bit rdy);
        step(1, i0, 64'h1000 + 64'(i0), 0, 0, 1, i1, 64'h1000 + 64'(i1), 0, 0, rdy);
    endtask

    // Asserts reset between edges and checks the outputs fall immediately.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        drive_idle();
        #1;
        model_clear();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_halted", 64'(halted), 64'h0);
        check("rst_overflow", 64'(overflow_err), 64'h0);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_clear();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Single lane with 1-cycle latency.
        step(1, 32'h0000_0013, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 1);
        check("single_inst", 64'(out_inst), 64'h13);
        check("single_dnpc", out_dnpc, 64'h8000_0004);
        idle(1);
        check("single_drained", 64'(out_valid), 64'h0);

        // Dual-lane ordering and a lone lane-1 record.
        lanes(32'hA, 32'hB, 1);
        check("dual_first", 64'(out_inst), 64'hA);
        idle(1);
        check("dual_second", 64'(out_inst), 64'hB);
        step(0, 0, 0, 0, 0, 1, 32'hC, 64'h2000, 0, 0, 1);
        check("lone_c1", 64'(out_inst), 64'hC);
        idle(1);
        check("lone_c1_single", 64'(out_valid), 64'h0);

        // Backpressure to full, then one record while stalled.
        for (int i = 0; i < 4; i++) lanes(32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i), 0);
        check("bp_stall", 64'(commit_stall), 64'h1);
        lane0(32'h999, 0, 0, 0);
        check("bp_overflow", 64'(overflow_err), 64'h1);
        for (int i = 0; i < 8; i++) begin
            check("bp_order", 64'(out_inst), 64'h100 + 64'(i));
            idle(1);
        end
        check("bp_empty", 64'(out_valid), 64'h0);
        do_reset();

        // Invalid instruction halts the stream; younger lane discarded.
        step(1, 32'hDEAD, 64'h40, 0, 1, 1, 32'hBEEF, 64'h44, 0, 0, 1);
        check("inv_inst", 64'(out_inst), 64'hDEAD);
        check("inv_flag", 64'(out_invalid), 64'h1);
        check("inv_stall", 64'(commit_stall), 64'h1);
        idle(1);
        check("inv_halted", 64'(halted), 64'h1);
        for (int i = 0; i < 3; i++) idle(1);
        check("inv_halted_sticky", 64'(halted), 64'h1);
        do_reset();

        // Kill passthrough keeps sequencing in RUN.
        lane0(32'h77, 1, 0, 1);
        check("kill_flag", 64'(out_kill), 64'h1);
        check("kill_run", 64'(commit_stall), 64'h0);
        idle(1);

        // Asynchronous reset with five records buffered.
        lanes(32'h1, 32'h2, 0);
        lanes(32'h3, 32'h4, 0);
        lane0(32'h5, 0, 0, 0);
        check("pre_rst_valid", 64'(out_valid), 64'h1);
        do_reset();
        idle(1);

        // Randomised traffic; commit mostly honours the stall.
        for (int n = 0; n < 3000; n++) begin
            bit v0, v1, x0, x1, rdy;
            v0  = ($urandom_range(0, 99) < 60);
            v1  = ($urandom_range(0, 99) < 50);
            x0  = ($urandom_range(0, 79) == 0);
            x1  = ($urandom_range(0, 79) == 0);
            rdy = ($urandom_range(0, 99) < 65);
            if (model_stall() && $urandom_range(0, 49) != 0) begin
                v0 = 0;
                v1 = 0;
            end
            step(v0, $urandom, {$urandom, $urandom}, 1'($urandom), x0,
                 v1, $urandom, {$urandom, $urandom}, 1'($urandom), x1, rdy);
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
                do_reset();
            end
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
